// File: rtl/lampfpu_tay_rnd_queue.sv
// Purpose : round-to-nearest-even of the Taylor multiplier result, pack to
//           bfloat16 and buffer it in a DEPTH-entry FIFO toward the exp accumulator.
// Latency : 1 cycle from valid_i to res_valid_o/res_o (push and head update on one edge).
// Backpr. : valid/ready on the output; the multiplier cannot stall, so space_o tells the
//           sequencer whether one more in-flight result still fits. Overruns are dropped
//           and recorded in flags_o[0].
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-low reset
//   valid_i             1-cycle pulse per multiplier result
//   s_i, e_i, f_i       sign, post-norm exponent, {ovf,hidden,frac,G,R,S}
//   isToRound_i         0: special value, exponent/fraction passed through untouched
//   isOverflow_i        overflow already detected upstream
//   isUnderflow_i       underflow already detected upstream
//   space_o             >=2 free entries after this cycle's push/pop
//   res_valid_o/ready_i FIFO head handshake
//   res_o               packed {s,e,frac} at the FIFO head
//   flags_o             sticky {overflow, underflow, inexact, drop_err}
//   clr_flags_i         synchronous clear of flags_o (a same-cycle event still sets its bit)
module lampfpu_tay_rnd_queue #(
  parameter int E_DW  = 8,
  parameter int F_DW  = 7,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   s_i,
  input  logic [E_DW-1:0]        e_i,
  input  logic [F_DW+4:0]        f_i,
  input  logic                   isToRound_i,
  input  logic                   isOverflow_i,
  input  logic                   isUnderflow_i,
  output logic                   space_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [E_DW+F_DW:0]     res_o,
  output logic [3:0]             flags_o,
  input  logic                   clr_flags_i
);

  localparam int W  = 1 + E_DW + F_DW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------------------
  // Rounding (purely combinational on the input result)
  // ---------------------------------------------------------------------------
  logic            w_lsb, w_g, w_rs, w_up, w_inexact;
  logic [W-1:0]    w_sum;
  logic [E_DW-1:0] w_e_rnd, w_e;
  logic [F_DW-1:0] w_frac;
  logic            w_inf, w_ovf, w_unf;
  logic [W-1:0]    w_wdat;

  assign w_lsb     = f_i[3];
  assign w_g       = f_i[2];
  assign w_rs      = f_i[1] | f_i[0];
  // Special values bypass rounding entirely: no increment, never inexact.
  assign w_up      = isToRound_i & w_g & (w_rs | w_lsb);
  assign w_inexact = isToRound_i & (w_g | w_rs);

  // Adding into the concatenated {e,frac} lets a fraction carry ripple into the
  // exponent, which handles both subnormal->normal promotion and mantissa wrap.
  assign w_sum   = {1'b0, e_i, f_i[F_DW+2:3]} + W'(w_up);
  assign w_e_rnd = w_sum[E_DW+F_DW-1:F_DW];
  // Top bit only sets if e_i was already all-ones; treat it as infinity too.
  assign w_inf   = isToRound_i & (w_sum[W-1] | (&w_e_rnd));

  always_comb begin
    w_e    = w_e_rnd;
    w_frac = w_sum[F_DW-1:0];
    if (w_inf) begin
      w_e    = '1;
      w_frac = '0;
    end
  end

  assign w_ovf  = isOverflow_i | w_inf;
  assign w_unf  = isUnderflow_i & w_inexact;
  assign w_wdat = {s_i, w_e, w_frac};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_res;
  logic [3:0]      r_flags;

  logic            w_full, w_pop, w_push, w_drop;
  logic [CW-1:0]   w_count_nxt, w_remain;
  logic [AW-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [W-1:0]    w_head_nxt;
  logic [3:0]      w_flags_nxt;

  assign res_valid_o = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = res_valid_o & res_ready_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
  assign w_push      = valid_i & (~w_full | w_pop);
  assign w_drop      = valid_i & w_full & ~w_pop;

  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_remain     = r_count - CW'(w_pop);
  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;

  // Two free slots are needed: one for a result issued now and one for the
  // result already in flight through the multiplier.
  assign space_o = (w_count_nxt <= CW'(DEPTH - 2));

  // res_o is a register holding the next head so it is glitch-free and simply
  // keeps its last value once the FIFO drains.
  always_comb begin
    w_head_nxt = r_res;
    if (w_count_nxt != '0) begin
      if (w_remain == '0) begin
        // FIFO is empty after the pop, so the new head is the entry being pushed.
        w_head_nxt = w_wdat;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // New events are ORed in after the clear so they win over a same-cycle clear.
  always_comb begin
    w_flags_nxt = clr_flags_i ? 4'b0000 : r_flags;
    if (w_push) begin
      w_flags_nxt[3] = w_flags_nxt[3] | w_ovf;
      w_flags_nxt[2] = w_flags_nxt[2] | w_unf;
      w_flags_nxt[1] = w_flags_nxt[1] | w_inexact;
    end
    if (w_drop) begin
      w_flags_nxt[0] = 1'b1;
    end
  end

  // Storage array needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_res    <= '0;
      r_flags  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_res    <= w_head_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

  assign res_o   = r_res;
  assign flags_o = r_flags;

endmodule

// File: tb/tb_lampfpu_tay_rnd_queue.sv
module tb_lampfpu_tay_rnd_queue;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isToRound_i;
  logic        isOverflow_i;
  logic        isUnderflow_i;
  logic        space_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_o;
  logic [3:0]  flags_o;
  logic        clr_flags_i;

  lampfpu_tay_rnd_queue #(.E_DW(8), .F_DW(7), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isToRound_i   (isToRound_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .space_o       (space_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_o         (res_o),
    .flags_o       (flags_o),
    .clr_flags_i   (clr_flags_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: valid must track the expected queue; each pop compares the head.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("mon_valid", {15'd0, res_valid_o}, {15'd0, exp_q.size() != 0});
      if (res_valid_o && res_ready_i && exp_q.size() != 0) begin
        chk("mon_res", res_o, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+#1; drives one result for one cycle.
  task automatic push(input logic s, input logic [7:0] e, input logic [11:0] f,
                      input logic tr, input logic un, input logic clr,
                      input logic [15:0] exp, input logic drop);
    valid_i       = 1'b1;
    s_i           = s;
    e_i           = e;
    f_i           = f;
    isToRound_i   = tr;
    isOverflow_i  = 1'b0;
    isUnderflow_i = un;
    clr_flags_i   = clr;
    @(posedge clk);
    if (!drop) exp_q.push_back(exp);
    #1;
    valid_i     = 1'b0;
    clr_flags_i = 1'b0;
  endtask

  task automatic clr_flags();
    clr_flags_i = 1'b1;
    @(posedge clk);
    #1;
    clr_flags_i = 1'b0;
  endtask

  task automatic drain();
    res_ready_i = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    res_ready_i = 1'b0;
  endtask

  logic [7:0]  fifo_e   [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  logic [6:0]  fifo_f   [5] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
  logic [15:0] fifo_exp [5] = '{16'h0800, 16'h0881, 16'h0902, 16'h0983, 16'h0A04};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; s_i = 1'b0; e_i = '0; f_i = '0;
    isToRound_i = 1'b1; isOverflow_i = 1'b0; isUnderflow_i = 1'b0;
    res_ready_i = 1'b0; clr_flags_i = 1'b0;
    #12;
    chk("rst_valid", {15'd0, res_valid_o}, 16'd0);
    chk("rst_res",   res_o, 16'h0000);
    chk("rst_flags", {12'd0, flags_o}, 16'd0);
    chk("rst_space", {15'd0, space_o}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Rounding vectors, consumer always ready
    res_ready_i = 1'b1;
    push(1'b0, 8'h7F, {1'b0, 1'b1, 7'h00, 3'b100}, 1'b1, 1'b0, 1'b0, 16'h3F80, 1'b0);
    chk("tie_even_flags", {12'd0, flags_o}, 16'h0002);
    push(1'b1, 8'h7F, {1'b0, 1'b1, 7'h00, 3'b100}, 1'b1, 1'b0, 1'b0, 16'hBF80, 1'b0);
    clr_flags();
    push(1'b0, 8'h7F, {1'b0, 1'b1, 7'h01, 3'b100}, 1'b1, 1'b0, 1'b0, 16'h3F82, 1'b0);
    chk("tie_odd_flags", {12'd0, flags_o}, 16'h0002);
    clr_flags();
    chk("clr_flags", {12'd0, flags_o}, 16'h0000);
    push(1'b0, 8'h7F, {1'b0, 1'b1, 7'h7F, 3'b101}, 1'b1, 1'b0, 1'b0, 16'h4000, 1'b0);
    chk("carry_flags", {12'd0, flags_o}, 16'h0002);
    clr_flags();
    push(1'b0, 8'hFE, {1'b0, 1'b1, 7'h7F, 3'b101}, 1'b1, 1'b0, 1'b0, 16'h7F80, 1'b0);
    chk("to_inf_flags", {12'd0, flags_o}, 16'h000A);
    // event in the same cycle as clear: ovf cleared, inexact kept
    push(1'b0, 8'h7F, {1'b0, 1'b1, 7'h00, 3'b100}, 1'b1, 1'b0, 1'b1, 16'h3F80, 1'b0);
    chk("clr_vs_event", {12'd0, flags_o}, 16'h0002);
    clr_flags();
    push(1'b0, 8'h00, {1'b0, 1'b0, 7'h7F, 3'b110}, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0);
    chk("subn_no_unf", {12'd0, flags_o}, 16'h0002);
    clr_flags();
    push(1'b0, 8'h00, {1'b0, 1'b0, 7'h7F, 3'b110}, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b0);
    chk("subn_unf", {12'd0, flags_o}, 16'h0006);
    clr_flags();
    push(1'b0, 8'hFF, {1'b0, 1'b1, 7'h40, 3'b100}, 1'b0, 1'b0, 1'b0, 16'h7FC0, 1'b0);
    chk("special_flags", {12'd0, flags_o}, 16'h0000);
    drain();

    // FIFO fill with no consumer: 4 held, 5th dropped
    clr_flags();
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; s_i = 1'b0; e_i = fifo_e[i];
      f_i = {1'b0, 1'b1, fifo_f[i], 3'b000};
      isToRound_i = 1'b1; isUnderflow_i = 1'b0;
      @(negedge clk);
      chk($sformatf("space_push%0d", i), {15'd0, space_o}, {15'd0, (i < 2)});
      @(posedge clk);
      if (i < 4) exp_q.push_back(fifo_exp[i]);
      #1;
    end
    valid_i = 1'b0;
    chk("drop_flags", {12'd0, flags_o}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_head", res_o, 16'h0800);
      chk("full_space", {15'd0, space_o}, 16'd0);
    end
    @(posedge clk); #1;
    drain();

    // Full FIFO with simultaneous push and pop
    clr_flags();
    for (int i = 0; i < 4; i++)
      push(1'b0, fifo_e[i], {1'b0, 1'b1, fifo_f[i], 3'b000}, 1'b1, 1'b0, 1'b0, fifo_exp[i], 1'b0);
    res_ready_i = 1'b1;
    push(1'b0, 8'h20, {1'b0, 1'b1, 7'h05, 3'b000}, 1'b1, 1'b0, 1'b0, 16'h1005, 1'b0);
    res_ready_i = 1'b0;
    chk("pushpop_no_drop", {12'd0, flags_o}, 16'h0000);
    @(negedge clk);
    chk("pushpop_full", {15'd0, space_o}, 16'd0);
    chk("pushpop_head", res_o, 16'h0881);

    // Asynchronous reset in the middle of a burst
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    valid_i = 1'b0;
    #1;
    chk("midrst_valid", {15'd0, res_valid_o}, 16'd0);
    chk("midrst_flags", {12'd0, flags_o}, 16'd0);
    chk("midrst_space", {15'd0, space_o}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    push(1'b0, 8'h7F, {1'b0, 1'b1, 7'h01, 3'b100}, 1'b1, 1'b0, 1'b0, 16'h3F82, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
